// File: rtl/rx_udp_demux_if.sv
// Stream, channel-table and result bundle for the UDP receive demultiplexer.
// master = the side feeding bytes and programming the channel table,
// slave  = the parser itself.
interface rx_udp_demux_if #(
  parameter int OCT    = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  // channel table: channel i listens on ch_port[16*i+15:16*i]
  logic [NUM_CH*16-1:0] ch_port;
  logic [NUM_CH-1:0]    ch_en;

  // IPv4-payload byte stream (UDP header followed by payload)
  logic                 rx_data_v;
  logic [OCT-1:0]       rx_data;

  // captured header fields and match result
  logic [15:0]          rx_src_port;
  logic [15:0]          rx_dst_port;
  logic [15:0]          rx_udp_len;
  logic [CH_W-1:0]      rx_udp_ch;

  // demultiplexed payload stream and status
  logic                 rx_udp_data_v;
  logic [OCT-1:0]       rx_udp_data;
  logic                 rx_udp_last;
  logic                 rx_udp_irq;
  logic                 rx_udp_err;
  logic [15:0]          rx_drop_cnt;

  modport master (
    output ch_port, ch_en, rx_data_v, rx_data,
    input  rx_src_port, rx_dst_port, rx_udp_len, rx_udp_ch,
    input  rx_udp_data_v, rx_udp_data, rx_udp_last,
    input  rx_udp_irq, rx_udp_err, rx_drop_cnt
  );

  modport slave (
    input  ch_port, ch_en, rx_data_v, rx_data,
    output rx_src_port, rx_dst_port, rx_udp_len, rx_udp_ch,
    output rx_udp_data_v, rx_udp_data, rx_udp_last,
    output rx_udp_irq, rx_udp_err, rx_drop_cnt
  );
endinterface

// File: rtl/rx_udp_demux.sv
// UDP receive demultiplexer.
// Parses the 8-byte UDP header from the IPv4-payload stream, matches the
// destination port against a programmable channel table (lowest index wins),
// forwards payload bytes of matching datagrams with one cycle of latency,
// trims padding beyond the UDP length and flags bad-length / truncated
// datagrams. Datagrams matching no channel are counted and swallowed.
module rx_udp_demux #(
  parameter int OCT    = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              RX_CLK,
  input  logic              rst,
  rx_udp_demux_if.slave     bus
);

  typedef enum logic [1:0] {
    S_SYNC,     // after reset: wait for an inter-datagram gap
    S_HDR,      // header bytes 0..7
    S_PAYLOAD,  // payload bytes 8..len-1
    S_DRAIN     // padding / rejected bytes until the gap
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;        // index of the byte being accepted
  logic            hit_q, hit_d;        // current datagram matched a channel
  logic [15:0]     src_q, src_d;
  logic [15:0]     dst_q, dst_d;
  logic [15:0]     len_q, len_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            data_v_q, data_v_d;
  logic [OCT-1:0]  data_q, data_d;
  logic            last_q, last_d;
  logic            irq_q, irq_d;
  logic            err_q, err_d;
  logic [15:0]     drop_q, drop_d;

  // Destination port / length as they stand once their low byte arrives.
  logic [15:0]     dst_full;
  logic [15:0]     len_full;

  assign dst_full = {dst_q[15:8], bus.rx_data};
  assign len_full = {len_q[15:8], bus.rx_data};

  // Per-channel comparators against the destination port being completed.
  // Only consulted on header byte 3, so the table is effectively sampled
  // once per datagram.
  logic [NUM_CH-1:0] match_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_match
    assign match_vec[gi] = bus.ch_en[gi] &&
                           (bus.ch_port[16*gi +: 16] == dst_full);
  end

  logic            match_any;
  logic [CH_W-1:0] match_idx;

  assign match_any = |match_vec;

  // Priority encoder: walk from the top so the lowest matching index wins.
  always_comb begin
    match_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_idx = CH_W'(i);
      end
    end
  end

  // Next-state / next-output computation for the whole parser.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    ch_d     = ch_q;
    data_d   = data_q;
    drop_d   = drop_q;
    // pulses and per-beat qualifiers default low every cycle
    data_v_d = 1'b0;
    last_d   = 1'b0;
    irq_d    = 1'b0;
    err_d    = 1'b0;

    if (state_q == S_SYNC) begin
      // Only a gap tells us where the next datagram starts.
      cnt_d = '0;
      if (!bus.rx_data_v) begin
        state_d = S_HDR;
      end
    end else if (!bus.rx_data_v) begin
      // Gap: re-arm for the next header. A gap while still short of the
      // required byte count means truncation. DRAIN is reached only after a
      // complete datagram or an already-reported bad length, so it never
      // reports here.
      state_d = S_HDR;
      cnt_d   = '0;
      if ((state_q == S_HDR || state_q == S_PAYLOAD) && cnt_q != 16'd0) begin
        err_d = 1'b1;
      end
    end else begin
      // Count accepted bytes; only DRAIN can run long enough to saturate.
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end

      case (state_q)
        S_HDR: begin
          case (cnt_q)
            16'd0: src_d[15:8] = bus.rx_data;
            16'd1: src_d[7:0]  = bus.rx_data;
            16'd2: dst_d[15:8] = bus.rx_data;
            16'd3: begin
              dst_d[7:0] = bus.rx_data;
              hit_d      = match_any;
              if (match_any) begin
                ch_d = match_idx;
              end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
              end
            end
            16'd4: len_d[15:8] = bus.rx_data;
            16'd5: begin
              len_d[7:0] = bus.rx_data;
              // A length shorter than the header itself is unusable.
              if (len_full < 16'd8) begin
                err_d   = 1'b1;
                state_d = S_DRAIN;
              end
            end
            16'd7: begin
              // Bytes 6-7 are the checksum and are ignored. A header-only
              // datagram completes right here.
              if (len_q == 16'd8) begin
                irq_d   = hit_q;
                state_d = S_DRAIN;
              end else begin
                state_d = S_PAYLOAD;
              end
            end
            default: ;
          endcase
        end

        S_PAYLOAD: begin
          if (hit_q) begin
            data_v_d = 1'b1;
            data_d   = bus.rx_data;
            last_d   = (cnt_q == len_q - 16'd1);
            irq_d    = (cnt_q == len_q - 16'd1);
          end
          if (cnt_q == len_q - 16'd1) begin
            state_d = S_DRAIN;
          end
        end

        default: ;  // S_DRAIN: discard padding until the gap
      endcase
    end
  end

  // Single state register for FSM, datapath and outputs.
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q  <= S_SYNC;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      ch_q     <= '0;
      data_v_q <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      ch_q     <= ch_d;
      data_v_q <= data_v_d;
      data_q   <= data_d;
      last_q   <= last_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.rx_src_port   = src_q;
  assign bus.rx_dst_port   = dst_q;
  assign bus.rx_udp_len    = len_q;
  assign bus.rx_udp_ch     = ch_q;
  assign bus.rx_udp_data_v = data_v_q;
  assign bus.rx_udp_data   = data_q;
  assign bus.rx_udp_last   = last_q;
  assign bus.rx_udp_irq    = irq_q;
  assign bus.rx_udp_err    = err_q;
  assign bus.rx_drop_cnt   = drop_q;

endmodule

// File: tb/tb_rx_udp_demux.sv
// Self-checking bench for rx_udp_demux: directed scenarios plus randomized
// datagrams, all compared cycle by cycle against a reference model derived
// from the UDP framing rules (field offsets, max(len,8), lowest-index match).
`timescale 1ns/1ps
module tb_rx_udp_demux;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic RX_CLK = 1'b0;
  logic rst    = 1'b1;

  always #5 RX_CLK = ~RX_CLK;

  rx_udp_demux_if #(.OCT(8), .NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  rx_udp_demux #(.OCT(8), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .RX_CLK (RX_CLK),
    .rst    (rst),
    .bus    (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // channel table as the bench sees it
  logic [15:0]       port_tbl [NUM_CH];
  logic [NUM_CH-1:0] en_tbl;

  // datagram under construction
  logic [7:0] pkt [0:63];

  // model state carried between datagrams
  int exp_drop = 0;

  task automatic apply_table();
    for (int i = 0; i < NUM_CH; i++) bus.ch_port[16*i +: 16] = port_tbl[i];
    bus.ch_en = en_tbl;
  endtask

  task automatic random_table();
    for (int i = 0; i < NUM_CH; i++) port_tbl[i] = 16'h1000 + 16'($urandom_range(0, 7));
    en_tbl = NUM_CH'($urandom);
    apply_table();
  endtask

  task automatic build(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    for (int i = 0; i < 64; i++) pkt[i] = 8'($urandom);
    pkt[0] = src[15:8]; pkt[1] = src[7:0];
    pkt[2] = dst[15:8]; pkt[3] = dst[7:0];
    pkt[4] = len[15:8]; pkt[5] = len[7:0];
  endtask

  // Drive pkt[0..n-1], then one idle cycle, checking every output cycle.
  // rst_at >= 0 pulses reset together with that byte index.
  task automatic send(input string name, input int n, input int rst_at, input bit scramble);
    logic [15:0] dst, len, src;
    int lenv, full, hit_idx, beats, irqs, errs;
    bit hit, bad_len;
    logic exp_v, exp_last, exp_irq, exp_err;

    src = {pkt[0], pkt[1]};
    dst = {pkt[2], pkt[3]};
    len = {pkt[4], pkt[5]};
    lenv = int'(len);
    hit_idx = -1;
    if (n >= 4) begin
      for (int i = 0; i < NUM_CH; i++)
        if (hit_idx < 0 && en_tbl[i] && port_tbl[i] == dst) hit_idx = i;
    end
    hit     = (hit_idx >= 0);
    bad_len = (n >= 6) && (lenv < 8);
    full    = (lenv > 8) ? lenv : 8;
    beats = 0; irqs = 0; errs = 0;

    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        bus.rx_data_v = 1'b1;
        bus.rx_data   = pkt[j];
      end else begin
        bus.rx_data_v = 1'b0;
        bus.rx_data   = 8'($urandom);
      end
      if (j == rst_at) rst = 1'b1;
      if (scramble && j == 4) random_table();
      @(posedge RX_CLK); #1;
      rst = 1'b0;

      exp_v    = hit && (j < n) && (j >= 8) && (j < lenv);
      exp_last = exp_v && (j == lenv - 1);
      exp_irq  = hit && !bad_len && (j < n) && (j == full - 1);
      exp_err  = (bad_len && j == 5) || (!bad_len && j == n && n > 0 && n < full);
      if (rst_at >= 0 && j >= rst_at) begin
        exp_v = 0; exp_last = 0; exp_irq = 0; exp_err = 0;
      end

      tests_run++;
      if (bus.rx_udp_data_v !== exp_v) begin
        tests_failed++;
        $display("FAIL %s data_v cyc%0d got %0b exp %0b", name, j, bus.rx_udp_data_v, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (bus.rx_udp_data !== pkt[j]) begin
          tests_failed++;
          $display("FAIL %s data cyc%0d got %02h exp %02h", name, j, bus.rx_udp_data, pkt[j]);
        end
      end
      tests_run++;
      if (bus.rx_udp_last !== exp_last) begin
        tests_failed++;
        $display("FAIL %s last cyc%0d got %0b exp %0b", name, j, bus.rx_udp_last, exp_last);
      end
      tests_run++;
      if (bus.rx_udp_irq !== exp_irq) begin
        tests_failed++;
        $display("FAIL %s irq cyc%0d got %0b exp %0b", name, j, bus.rx_udp_irq, exp_irq);
      end
      tests_run++;
      if (bus.rx_udp_err !== exp_err) begin
        tests_failed++;
        $display("FAIL %s err cyc%0d got %0b exp %0b", name, j, bus.rx_udp_err, exp_err);
      end
      if (exp_v) beats++;
      if (exp_irq) irqs++;
      if (exp_err) errs++;
    end

    if (rst_at >= 0) begin
      exp_drop = 0;
      src = '0; dst = '0; len = '0;
    end else if (n >= 4 && !hit && exp_drop < 16'hFFFF) begin
      exp_drop++;
    end

    if (rst_at >= 0 || n >= 6) begin
      tests_run++;
      if (bus.rx_src_port !== src || bus.rx_dst_port !== dst || bus.rx_udp_len !== len) begin
        tests_failed++;
        $display("FAIL %s fields got %04h/%04h/%04h exp %04h/%04h/%04h", name,
                 bus.rx_src_port, bus.rx_dst_port, bus.rx_udp_len, src, dst, len);
      end
    end
    if (rst_at < 0 && hit) begin
      tests_run++;
      if (bus.rx_udp_ch !== CH_W'(hit_idx)) begin
        tests_failed++;
        $display("FAIL %s ch got %0d exp %0d", name, bus.rx_udp_ch, hit_idx);
      end
    end
    tests_run++;
    if (bus.rx_drop_cnt !== 16'(exp_drop)) begin
      tests_failed++;
      $display("FAIL %s drop_cnt got %0d exp %0d", name, bus.rx_drop_cnt, exp_drop);
    end
    $display("[TB] %s n=%0d len=%04h hit=%0d beats=%0d irq=%0d err=%0d drop=%0d",
             name, n, len, hit_idx, beats, irqs, errs, exp_drop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_data_v = 1'b0;
    bus.rx_data   = '0;
    repeat (3) @(posedge RX_CLK);
    #1;
    tests_run++;
    if (bus.rx_udp_data_v !== 0 || bus.rx_udp_last !== 0 || bus.rx_udp_irq !== 0 ||
        bus.rx_udp_err !== 0 || bus.rx_drop_cnt !== 0 || bus.rx_src_port !== 0 ||
        bus.rx_dst_port !== 0 || bus.rx_udp_len !== 0 || bus.rx_udp_ch !== 0) begin
      tests_failed++;
      $display("FAIL reset outputs not zero: v=%0b drop=%0d src=%04h", bus.rx_udp_data_v,
               bus.rx_drop_cnt, bus.rx_src_port);
    end
    rst = 1'b0;
    @(posedge RX_CLK); #1;  // idle cycle lets the parser leave SYNC
    exp_drop = 0;
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    for (int i = 0; i < NUM_CH; i++) port_tbl[i] = 16'h0;
    port_tbl[1] = 16'h1234;
    en_tbl = 4'b0010;
    apply_table();
    build(16'hBEEF, 16'h1234, 16'h000C);
    for (int k = 0; k < 4; k++) pkt[8+k] = 8'hA0 + 8'(k);
    send("basic", 12, -1, 1'b0);
  endtask

  task automatic test_miss();
    build(16'hBEEF, 16'h5555, 16'h000C);
    send("miss", 12, -1, 1'b0);
  endtask

  task automatic test_priority();
    port_tbl[0] = 16'h0050; port_tbl[2] = 16'h0050;
    en_tbl = 4'b0101;
    apply_table();
    build(16'h0400, 16'h0050, 16'h000C);
    send("priority", 12, -1, 1'b0);
  endtask

  task automatic test_padding();
    build(16'h0101, 16'h0050, 16'h000A);
    send("padding", 14, -1, 1'b0);
  endtask

  task automatic test_bad_len();
    build(16'h0202, 16'h0050, 16'h0004);
    send("bad_len", 10, -1, 1'b0);
  endtask

  task automatic test_truncation();
    build(16'h0303, 16'h0050, 16'h0010);
    send("truncation", 11, -1, 1'b0);
  endtask

  task automatic test_len8();
    build(16'h0404, 16'h0050, 16'h0008);
    send("len8", 8, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    build(16'h0505, 16'h5555, 16'h000C);
    send("pre_reset_miss", 12, -1, 1'b0);
    build(16'h0606, 16'h0050, 16'h0010);
    send("reset_mid", 16, 11, 1'b0);
    build(16'h0707, 16'h0050, 16'h000C);
    send("after_reset", 12, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] dst, len;
    int r, full, n;
    for (int t = 0; t < 80; t++) begin
      random_table();
      dst = ($urandom_range(0, 3) != 0) ? 16'h1000 + 16'($urandom_range(0, 7)) : 16'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      len = 16'($urandom_range(0, 7));
      else if (r == 1) len = 16'h0008;
      else if (r == 2) len = 16'hFFFF;
      else             len = 16'($urandom_range(9, 40));
      full = (int'(len) > 8) ? int'(len) : 8;
      if (full > 48) full = 48;
      if ($urandom_range(0, 3) == 0) n = $urandom_range(1, full - 1);
      else                           n = full + $urandom_range(0, 4);
      build(16'($urandom), dst, len);
      send("random", n, -1, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    bus.rx_data_v = 1'b0;
    bus.rx_data   = '0;
    bus.ch_port   = '0;
    bus.ch_en     = '0;
    test_reset();
    test_basic();
    test_miss();
    test_priority();
    test_padding();
    test_bad_len();
    test_truncation();
    test_len8();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
